// File: rtl/hdmi_out_timing_gen_if.sv
// Pixel-FIFO read port and HDMI transmitter video bus of the output timing generator.
// The timing generator is the master; the FIFO/transmitter side is the slave.
interface hdmi_out_timing_gen_if;
  logic        pix_req;
  logic        pix_empty;
  logic [23:0] pix_data;
  logic [23:0] hdmi_out_data;
  logic        hdmi_out_hs;
  logic        hdmi_out_vs;
  logic        hdmi_out_de;

  modport master (
    output pix_req,
    output hdmi_out_data,
    output hdmi_out_hs,
    output hdmi_out_vs,
    output hdmi_out_de,
    input  pix_empty,
    input  pix_data
  );

  modport slave (
    input  pix_req,
    input  hdmi_out_data,
    input  hdmi_out_hs,
    input  hdmi_out_vs,
    input  hdmi_out_de,
    output pix_empty,
    output pix_data
  );
endinterface

// File: rtl/hdmi_out_timing_gen.sv
// HDMI/DVI raster timing generator: requests pixels from the frame-buffer FIFO and drives
// aligned RGB/hs/vs/de to the transmitter, plus frame-start, frame-parity and underflow status.
module hdmi_out_timing_gen #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic                         iclk,
  input  logic                         s_rst_n,
  input  logic                         cfg_done,
  input  logic                         tx_en,
  input  logic                         clr_underflow,
  hdmi_out_timing_gen_if.master        vid,
  output logic                         frame_start,
  output logic                         frame_sel,
  output logic                         underflow,
  output logic                         busy
);

  localparam logic [11:0] H_LAST     = 12'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam logic [11:0] H_SYNC_END = 12'(H_SYNC);
  localparam logic [11:0] H_ACT_BEG  = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_ACT_END  = 12'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [11:0] V_LAST     = 12'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
  localparam logic [11:0] V_SYNC_END = 12'(V_SYNC);
  localparam logic [11:0] V_ACT_BEG  = 12'(V_SYNC + V_BP);
  localparam logic [11:0] V_ACT_END  = 12'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic        HS_ON      = HS_POL;
  localparam logic        HS_OFF     = !HS_POL;
  localparam logic        VS_ON      = VS_POL;
  localparam logic        VS_OFF     = !VS_POL;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
  } tim_t;

  state_e      state_q, state_d;
  logic [11:0] h_q, h_d, v_q, v_d;
  logic        last_s, flush_s, run_s;
  tim_t        tim_a_d, tim_a_q, tim_b_q;
  logic        emp_b_q;
  logic [23:0] data_q;
  logic        de_q, hs_q, vs_q, fs_q, sel_q, uf_q, busy_q;

  assign last_s  = (h_q == H_LAST) && (v_q == V_LAST);
  // Losing the transmitter configuration aborts the frame and discards everything in flight.
  assign flush_s = (state_q != ST_IDLE) && !cfg_done;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_done && tx_en) state_d = ST_RUN;
        else                   state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (!cfg_done)   state_d = ST_IDLE;
        else if (!tx_en) state_d = last_s ? ST_IDLE : ST_DRAIN;
        else             state_d = ST_RUN;
      end
      ST_DRAIN: begin
        if (!cfg_done)   state_d = ST_IDLE;
        else if (last_s) state_d = tx_en ? ST_RUN : ST_IDLE;
        else             state_d = ST_DRAIN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    h_d = 12'd0;
    v_d = 12'd0;
    if ((state_q == ST_IDLE) || (state_d == ST_IDLE)) begin
      h_d = 12'd0;
      v_d = 12'd0;
    end else if (h_q == H_LAST) begin
      h_d = 12'd0;
      v_d = (v_q == V_LAST) ? 12'd0 : v_q + 12'd1;
    end else begin
      h_d = h_q + 12'd1;
      v_d = v_q;
    end
  end

  // Decode from next-state counters so the first pipeline stage is aligned with h_q/v_q.
  always_comb begin
    tim_a_d    = '0;
    run_s      = (state_d != ST_IDLE);
    tim_a_d.de = run_s && (h_d >= H_ACT_BEG) && (h_d < H_ACT_END)
                       && (v_d >= V_ACT_BEG) && (v_d < V_ACT_END);
    tim_a_d.hs = run_s && (h_d < H_SYNC_END);
    tim_a_d.vs = run_s && (v_d < V_SYNC_END);
    tim_a_d.fs = run_s && (h_d == 12'd0) && (v_d == 12'd0);
  end

  always_ff @(posedge iclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q <= ST_IDLE;
      h_q     <= 12'd0;
      v_q     <= 12'd0;
      tim_a_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      tim_a_q <= tim_a_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  // Stage B waits for pix_data; the output stage applies sync polarity and underflow blanking.
  always_ff @(posedge iclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      tim_b_q <= '0;
      emp_b_q <= 1'b0;
      data_q  <= 24'd0;
      de_q    <= 1'b0;
      hs_q    <= HS_OFF;
      vs_q    <= VS_OFF;
      fs_q    <= 1'b0;
      sel_q   <= 1'b1;
    end else if (flush_s) begin
      tim_b_q <= '0;
      emp_b_q <= 1'b0;
      data_q  <= 24'd0;
      de_q    <= 1'b0;
      hs_q    <= HS_OFF;
      vs_q    <= VS_OFF;
      fs_q    <= 1'b0;
    end else begin
      tim_b_q <= tim_a_q;
      emp_b_q <= tim_a_q.de && vid.pix_empty;
      data_q  <= (tim_b_q.de && !emp_b_q) ? vid.pix_data : 24'd0;
      de_q    <= tim_b_q.de;
      hs_q    <= tim_b_q.hs ? HS_ON : HS_OFF;
      vs_q    <= tim_b_q.vs ? VS_ON : VS_OFF;
      fs_q    <= tim_b_q.fs;
      sel_q   <= sel_q ^ tim_b_q.fs;
    end
  end

  // A new empty read wins over a simultaneous clear.
  always_ff @(posedge iclk or negedge s_rst_n) begin
    if (!s_rst_n)                          uf_q <= 1'b0;
    else if (tim_a_q.de && vid.pix_empty)  uf_q <= 1'b1;
    else if (clr_underflow)                uf_q <= 1'b0;
    else                                   uf_q <= uf_q;
  end

  assign vid.pix_req       = tim_a_q.de;
  assign vid.hdmi_out_data = data_q;
  assign vid.hdmi_out_de   = de_q;
  assign vid.hdmi_out_hs   = hs_q;
  assign vid.hdmi_out_vs   = vs_q;
  assign frame_start       = fs_q;
  assign frame_sel         = sel_q;
  assign underflow         = uf_q;
  assign busy              = busy_q;

endmodule
